// File: rtl/reg_bank_ctrl_pkg.sv
// Shared encodings for the reg_bank command front end: opcodes, FSM states,
// bus widths and the registered command record.
package reg_bank_ctrl_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 4;
  localparam int END_W  = 2;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CONST = 2'b10,
    OP_RSV   = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR1   = 3'd1,
    ST_WR2   = 3'd2,
    ST_CN1   = 3'd3,
    ST_CN2   = 3'd4,
    ST_RDEN  = 3'd5,
    ST_RDCAP = 3'd6,
    ST_RESP  = 3'd7
  } state_e;

  typedef struct packed {
    cmd_op_e           op;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  wsel;
    logic [SEL_W-1:0]  selA;
    logic [SEL_W-1:0]  selB;
    logic [END_W-1:0]  endreg;
    logic              cnstA;
    logic              cnstB;
  } cmd_t;

endpackage

// File: rtl/reg_bank_ctrl.sv
// Command/response sequencer placed in front of reg_bank. Defining
// REGCTRL_RD_AFTER_WR_EN makes every WRITE read its register back on port A.
module reg_bank_ctrl
  import reg_bank_ctrl_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [SEL_W-1:0]  cmd_wsel_i,
  input  logic [SEL_W-1:0]  cmd_selA_i,
  input  logic [SEL_W-1:0]  cmd_selB_i,
  input  logic [END_W-1:0]  cmd_endreg_i,
  input  logic              cmd_cnstA_i,
  input  logic              cmd_cnstB_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dataA_o,
  output logic [DATA_W-1:0] rsp_dataB_o,
  output logic              rsp_err_o,
  output logic              regwe_o,
  output logic [DATA_W-1:0] inA_o,
  output logic [SEL_W-1:0]  selwreg_o,
  output logic [END_W-1:0]  endreg_o,
  output logic [SEL_W-1:0]  seloutA_o,
  output logic [SEL_W-1:0]  seloutB_o,
  output logic              cnstA_o,
  output logic              cnstB_o,
  output logic              enrregA_o,
  output logic              enrregB_o,
  input  logic [DATA_W-1:0] outA_i,
  input  logic [DATA_W-1:0] outB_i
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_accept_s;

  // Ready is masked while reset is asserted so nothing is accepted under reset.
  assign cmd_ready_o  = (state_q == ST_IDLE) & ~reset_i;
  assign cmd_accept_s = cmd_valid_i & cmd_ready_o;

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          case (cmd_op_e'(cmd_op_i))
            OP_READ:  state_d = ST_RDEN;
            OP_WRITE: state_d = ST_WR1;
            OP_CONST: state_d = ST_CN1;
            OP_RSV:   state_d = ST_RESP;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR1:   state_d = ST_WR2;
`ifdef REGCTRL_RD_AFTER_WR_EN
      ST_WR2:   state_d = ST_RDEN;
`else
      ST_WR2:   state_d = ST_RESP;
`endif
      ST_CN1:   state_d = ST_CN2;
      ST_CN2:   state_d = ST_RDCAP;
      ST_RDEN:  state_d = ST_RDCAP;
      ST_RDCAP: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bank strobes decoded from the current state only.
  always_comb begin
    regwe_o   = 1'b0;
    cnstA_o   = 1'b0;
    cnstB_o   = 1'b0;
    enrregA_o = 1'b0;
    enrregB_o = 1'b0;
    case (state_q)
      ST_WR1, ST_WR2: regwe_o = 1'b1;
      ST_CN1: begin
        cnstA_o = cmd_q.cnstA;
        cnstB_o = cmd_q.cnstB;
      end
      ST_CN2: begin
        cnstA_o   = cmd_q.cnstA;
        cnstB_o   = cmd_q.cnstB;
        enrregA_o = cmd_q.cnstA;
        enrregB_o = cmd_q.cnstB;
      end
      ST_RDEN: begin
        enrregA_o = 1'b1;
        enrregB_o = 1'b1;
      end
      default: begin
        regwe_o = 1'b0;
      end
    endcase
  end

  // Command capture, response capture and error flag next-state.
  always_comb begin
    cmd_d     = cmd_q;
    rsp_a_d   = rsp_a_q;
    rsp_b_d   = rsp_b_q;
    rsp_err_d = rsp_err_q;
    if (cmd_accept_s) begin
      cmd_d.op     = cmd_op_e'(cmd_op_i);
      cmd_d.data   = cmd_data_i;
      cmd_d.wsel   = cmd_wsel_i;
      cmd_d.selA   = cmd_selA_i;
      cmd_d.selB   = cmd_selB_i;
      cmd_d.endreg = cmd_endreg_i;
      cmd_d.cnstA  = cmd_cnstA_i;
      cmd_d.cnstB  = cmd_cnstB_i;
      rsp_err_d    = (cmd_op_e'(cmd_op_i) == OP_RSV);
    end else if (state_q == ST_RDCAP) begin
      rsp_a_d = outA_i;
      rsp_b_d = outB_i;
    end else begin
      cmd_d = cmd_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cmd_q     <= '0;
      rsp_a_q   <= '0;
      rsp_b_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Port A select: a WRITE may be steered to read back its own register.
  always_comb begin
`ifdef REGCTRL_RD_AFTER_WR_EN
    if (cmd_q.op == OP_WRITE) begin
      seloutA_o = cmd_q.wsel;
    end else begin
      seloutA_o = cmd_q.selA;
    end
`else
    if (cmd_q.op == OP_WRITE) begin
      seloutA_o = cmd_q.selA;
    end else begin
      seloutA_o = cmd_q.selA;
    end
`endif
  end

  assign inA_o       = cmd_q.data;
  assign selwreg_o   = cmd_q.wsel;
  assign endreg_o    = cmd_q.endreg;
  assign seloutB_o   = cmd_q.selB;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dataA_o = rsp_a_q;
  assign rsp_dataB_o = rsp_b_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl with a small behavioural reg_bank model
// (endreg 11 swaps 32-bit halves; constant code 0101 yields 0x00000000ffffffff).
module tb_reg_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [63:0] cmd_data = 64'h0;
  logic [3:0]  cmd_wsel = 4'h0, cmd_selA = 4'h0, cmd_selB = 4'h0;
  logic [1:0]  cmd_endreg = 2'b00;
  logic        cmd_cnstA = 1'b0, cmd_cnstB = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [63:0] rsp_dataA, rsp_dataB;
  logic        regwe, cnstA, cnstB, enrregA, enrregB;
  logic [63:0] inA;
  logic [3:0]  selwreg, seloutA, seloutB;
  logic [1:0]  endreg;
  logic [63:0] outA_q = 64'h0, outB_q = 64'h0;
  logic [63:0] bank_q [16] = '{default: 64'h0};

  always #5 clk = ~clk;

  reg_bank_ctrl dut (
    .clock_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_data_i(cmd_data), .cmd_wsel_i(cmd_wsel), .cmd_selA_i(cmd_selA),
    .cmd_selB_i(cmd_selB), .cmd_endreg_i(cmd_endreg),
    .cmd_cnstA_i(cmd_cnstA), .cmd_cnstB_i(cmd_cnstB),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dataA_o(rsp_dataA), .rsp_dataB_o(rsp_dataB), .rsp_err_o(rsp_err),
    .regwe_o(regwe), .inA_o(inA), .selwreg_o(selwreg), .endreg_o(endreg),
    .seloutA_o(seloutA), .seloutB_o(seloutB), .cnstA_o(cnstA), .cnstB_o(cnstB),
    .enrregA_o(enrregA), .enrregB_o(enrregB),
    .outA_i(outA_q), .outB_i(outB_q)
  );

  function automatic logic [63:0] swap_fn(input logic [63:0] d, input logic [1:0] er);
    if (er == 2'b11) return {d[31:0], d[63:32]};
    else return d;
  endfunction

  function automatic logic [63:0] const_fn(input logic [3:0] c);
    case (c)
      4'b0000: return 64'h0;
      4'b0101: return 64'h00000000ffffffff;
      4'b1111: return 64'hffffffffffffffff;
      default: return {60'h0, c};
    endcase
  endfunction

  // Behavioural bank: registered writes and registered read ports.
  always @(posedge clk) begin
    if (regwe) bank_q[selwreg] <= swap_fn(inA, endreg);
    if (enrregA) outA_q <= cnstA ? const_fn(seloutA) : bank_q[seloutA];
    if (enrregB) outB_q <= cnstB ? const_fn(seloutB) : bank_q[seloutB];
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt = 0, total_cnt = 0;
  int   cyc = 0, acc_cyc = 0;
  int   regwe_cnt = 0, we3_cnt = 0, enA_cnt = 0, enB_cnt = 0;
  int   cnA_cnt = 0, cnB_cnt = 0, excl_cnt = 0;
  logic rv_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe bookkeeping and scoreboard compare on each new response.
  always @(negedge clk) begin
    if (regwe) regwe_cnt++;
    if (regwe && selwreg == 4'd3) we3_cnt++;
    if (enrregA) enA_cnt++;
    if (enrregB) enB_cnt++;
    if (cnstA) cnA_cnt++;
    if (cnstB) cnB_cnt++;
    if (regwe && (enrregA || enrregB)) excl_cnt++;
    if (rsp_valid && !rv_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_dataA", rsp_dataA, e.a);
        check("rsp_dataB", rsp_dataB, e.b);
        check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
        check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
    rv_prev = rsp_valid;
  end

  task automatic issue(input logic [1:0] op, input logic [63:0] data,
                       input logic [3:0] ws, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [1:0] er, input logic ca, input logic cb,
                       input logic push, input logic [63:0] ea, input logic [63:0] eb,
                       input logic eerr, input int elat);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = data; cmd_wsel = ws; cmd_selA = sa; cmd_selB = sb;
    cmd_endreg = er; cmd_cnstA = ca; cmd_cnstB = cb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 50), 64'd1);
    acc_cyc = cyc;
    if (push) exp_q.push_back('{a: ea, b: eb, err: eerr, lat: elat});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 100), 64'd1);
    @(negedge clk);
  endtask

  int b_we, b_we3, b_ea, b_eb, b_ca, b_cb;

  task automatic snap();
    b_we = regwe_cnt; b_we3 = we3_cnt; b_ea = enA_cnt; b_eb = enB_cnt;
    b_ca = cnA_cnt; b_cb = cnB_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {63'h0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    check("rst_rsp_err", {63'h0, rsp_err}, 64'd0);
    check("rst_dataA", rsp_dataA, 64'h0);
    check("rst_regwe", {63'h0, regwe}, 64'd0);
    check("rst_inA", inA, 64'h0);
    check("rst_selwreg", {60'h0, selwreg}, 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", {63'h0, cmd_ready}, 64'd1);

    // WRITE 5 to r3
    snap();
`ifdef REGCTRL_RD_AFTER_WR_EN
    issue(2'b01, 64'h5, 4'd3, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 64'h5, 64'h0, 1'b0, 5);
`else
    issue(2'b01, 64'h5, 4'd3, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 3);
`endif
    wait_idle();
    check("write_regwe_cycles", 64'(regwe_cnt - b_we), 64'd2);
    check("write_selwreg3_cycles", 64'(we3_cnt - b_we3), 64'd2);

    // READ r3 / r0
    snap();
    issue(2'b00, 64'h0, 4'd0, 4'd3, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 64'h5, 64'h0, 1'b0, 3);
    wait_idle();
    check("read_enA_pulses", 64'(enA_cnt - b_ea), 64'd1);
    check("read_enB_pulses", 64'(enB_cnt - b_eb), 64'd1);
    check("read_regwe", 64'(regwe_cnt - b_we), 64'd0);

    // CONST on port B, code 0101
    snap();
    issue(2'b10, 64'h0, 4'd0, 4'd3, 4'b0101, 2'b00, 1'b0, 1'b1, 1'b1,
          64'h5, 64'h00000000ffffffff, 1'b0, 4);
    wait_idle();
    check("const_cnstB_cycles", 64'(cnB_cnt - b_cb), 64'd2);
    check("const_enB_pulses", 64'(enB_cnt - b_eb), 64'd1);
    check("const_enA_pulses", 64'(enA_cnt - b_ea), 64'd0);

    // Reserved opcode
    snap();
    issue(2'b11, 64'hffffffffffffffff, 4'd9, 4'd9, 4'd9, 2'b11, 1'b1, 1'b1, 1'b1,
          64'h5, 64'h00000000ffffffff, 1'b1, 1);
    wait_idle();
    check("rsv_no_strobe", 64'((regwe_cnt - b_we) + (enA_cnt - b_ea) + (enB_cnt - b_eb)
                               + (cnA_cnt - b_ca) + (cnB_cnt - b_cb)), 64'd0);

    // READ with response back-pressure; err must clear
    rsp_ready = 1'b0;
    issue(2'b00, 64'h0, 4'd0, 4'd3, 4'd3, 2'b00, 1'b0, 1'b0, 1'b1, 64'h5, 64'h5, 1'b0, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_timeout", 64'(n < 20), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {63'h0, rsp_valid}, 64'd1);
      check("hold_dataA", rsp_dataA, 64'h5);
      check("hold_dataB", rsp_dataB, 64'h5);
      check("hold_cmd_ready", {63'h0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // WRITE with half swap to r7
`ifdef REGCTRL_RD_AFTER_WR_EN
    issue(2'b01, 64'h0000000100000002, 4'd7, 4'd0, 4'd3, 2'b11, 1'b0, 1'b0, 1'b1,
          64'h0000000200000001, 64'h5, 1'b0, 5);
`else
    issue(2'b01, 64'h0000000100000002, 4'd7, 4'd0, 4'd3, 2'b11, 1'b0, 1'b0, 1'b1,
          64'h5, 64'h5, 1'b0, 3);
`endif
    wait_idle();

    // Reset in WR1 drops the command
    issue(2'b01, 64'hdead, 4'd2, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 0);
    check("wr1_regwe", {63'h0, regwe}, 64'd1);
    check("wr1_inA", inA, 64'hdead);
    check("wr1_selwreg", {60'h0, selwreg}, 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_regwe", {63'h0, regwe}, 64'd0);
    check("midrst_cmd_ready", {63'h0, cmd_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check("midrst_release_ready", {63'h0, cmd_ready}, 64'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", {63'h0, rsp_valid}, 64'd0);
    check("midrst_ready_hold", {63'h0, cmd_ready}, 64'd1);
    check("strobe_exclusive", 64'(excl_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is synchronous and active-high; ports are listed clock and reset first.
REQ-002 clock  in  1  master clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high master reset.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high on a clock edge.
REQ-005 cmd_op  in  2  00 READ, 01 WRITE, 10 CONST, 11 reserved.
REQ-006 cmd_data  in  64  write data.
REQ-007 cmd_wsel, cmd_selA, cmd_selB  in  4 each  write register index; port A and port B read selects (CONST: cmd_selB is the constant code).
REQ-008 cmd_endreg  in  2  write half-swap code; cmd_cnstA and cmd_cnstB  in  1 each  constant-mode enables.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake; rsp_dataA, rsp_dataB  out  64 each; rsp_err  out  1.
REQ-010 Bank side outputs: regwe 1, inA 64, selwreg 4, endreg 2, seloutA 4, seloutB 4, cnstA 1, cnstB 1, enrregA 1, enrregB 1; bank side inputs: outA 64, outB 64.

Function
REQ-011 The FSM SHALL have the states IDLE, WR1, WR2, CN1, CN2, RDEN, RDCAP and RESP.
REQ-012 cmd_ready SHALL be high only in IDLE; on an accepted command, all cmd_* fields SHALL be registered and SHALL drive inA/selwreg/endreg/seloutA/seloutB unchanged until return to IDLE.
REQ-013 Transitions on accept: WRITE->WR1, READ->RDEN, CONST->CN1, reserved->RESP with rsp_err=1 and data unchanged.
REQ-014 WR1 and WR2 SHALL drive regwe=1 (two cycles); WR2 then goes to RESP (or RDEN per REQ-024).
REQ-015 CN1 SHALL drive cnstA/cnstB from the registered bits; CN2 SHALL hold them and drive enrregA=cnstA and enrregB=cnstB; CN2 then goes to RDCAP.
REQ-016 RDEN SHALL drive enrregA=enrregB=1 for one cycle, then go to RDCAP.
REQ-017 At the end of RDCAP, outA and outB SHALL be captured into rsp_dataA and rsp_dataB; the next state is RESP.
REQ-018 RESP SHALL hold rsp_valid=1 and stable response data until rsp_ready=1, then return to IDLE; rsp_valid rising with rsp_ready already high SHALL complete in that single cycle.
REQ-019 Latency from accept edge to first rsp_valid cycle: READ 3 cycles, WRITE 3 cycles, CONST 4 cycles, reserved 1 cycle.
REQ-020 regwe, cnstA, cnstB, enrregA and enrregB SHALL be 0 in every state not listed for them; at most one of regwe/enrreg* SHALL be active in any cycle.
REQ-021 rsp_err SHALL be cleared on each new accepted valid op.

Reset
REQ-022 Reset SHALL override all other inputs, including mid-operation; the next state is IDLE and a partially issued command is dropped with no response.
REQ-023 Reset values: state IDLE, cmd_ready 0 during reset and 1 in the first cycle after it, rsp_valid 0, rsp_err 0, rsp_dataA/B 0, all bank control/select/data outputs 0.

Configuration
REQ-024 With REGCTRL_RD_AFTER_WR_EN defined, WR2 SHALL go to RDEN with seloutA forced to the write index, so a WRITE returns read-back data in rsp_dataA (latency 5 cycles); without it, WR2 goes to RESP and rsp_dataA/B keep their previous values.

Structure
REQ-025 A shared package SHALL hold the cmd_op encodings, the state enumeration and the widths 64, 4 and 2.
REQ-026 No sub-module is required; the FSM and its registers form one module instantiated in front of reg_bank.

Verification
REQ-027 After reset, WRITE data=0x0000000000000005, wsel=3, endreg=00 -> regwe high for exactly 2 cycles with selwreg=3; rsp_valid after 3 cycles, rsp_err=0.
REQ-028 READ selA=3, selB=0 after REQ-027 -> enrregA/B pulse once; rsp_dataA=0x0000000000000005.
REQ-029 CONST cnstB=1, selB=4'b0101 -> cnstB high 2 cycles, enrregB pulses once; rsp_dataB=0x00000000ffffffff.
REQ-030 cmd_op=11 -> rsp_valid on the next cycle, rsp_err=1, and no bank strobe.
REQ-031 Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0; then assert reset during WR1 of a new WRITE -> regwe=0 on the next cycle, cmd_ready=1 after release.
REQ-032 With REGCTRL_RD_AFTER_WR_EN, WRITE data=0x0000000100000002, wsel=7, endreg=11 -> rsp_dataA=0x0000000200000001 at latency 5.
